register_dump_reader: RTL

Debug-side reader for the ID-stage register bank's debug read port. On a start request it reads all bank registers in order, 0 to BANK_DEPTH-1, through the bank's read-enable/address port. It serialises each word MSB byte first into the debug UART transmitter using a start/done byte handshake. It sits in the debug unit between the bank and the UART TX, and runs only while the pipeline is halted (bank `i_enable` low).

---
 rtl/register_dump_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/register_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : register_dump_reader
// Brief    : Reads every bank register over the debug port and streams each
//            word MSB byte first into the debug UART TX. Define
//            DUMP_CHECKSUM_EN to append an XOR checksum byte to the dump.
// Revision : 1.0 - initial release
// ============================================================================
module register_dump_reader #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 5,
    parameter int BANK_DEPTH = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic                 o_read_enable,
    output logic [ADDR_SIZE-1:0] o_read_addr,
    input  logic [DATA_SIZE-1:0] i_read_data,
    output logic [BYTE_SIZE-1:0] o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int c_BYTES_PER_WORD = DATA_SIZE / BYTE_SIZE;
    localparam int c_CNT_W          = (c_BYTES_PER_WORD > 1) ? $clog2(c_BYTES_PER_WORD) : 1;
    localparam logic [c_CNT_W-1:0]   c_LAST_BYTE = c_CNT_W'(c_BYTES_PER_WORD - 1);
    localparam logic [ADDR_SIZE-1:0] c_LAST_ADDR = ADDR_SIZE'(BANK_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_LATCH     = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_TX   = 3'd4,
        ST_CSUM      = 3'd5,
        ST_CSUM_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [DATA_SIZE-1:0] r_shift;
    logic [BYTE_SIZE-1:0] w_top_byte;
    logic                 w_last_byte;
    logic                 w_last_addr;

    assign w_top_byte  = r_shift[DATA_SIZE-1 -: BYTE_SIZE];
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_last_addr = (r_addr == c_LAST_ADDR);
    assign o_read_addr = r_addr;

`ifdef DUMP_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] r_csum;

    // Folds in each byte on the cycle it is offered to the UART.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_csum <= '0;
        end else if (r_state == ST_SEND) begin
            r_csum <= r_csum ^ w_top_byte;
        end
    end
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        o_read_enable = 1'b0;
        o_tx_start    = 1'b0;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        o_tx_data     = w_top_byte;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next_state = ST_REQ;
            end
            ST_REQ: begin
                o_read_enable = 1'b1;
                w_next_state  = ST_LATCH;
            end
            ST_LATCH: w_next_state = ST_SEND;
            ST_SEND: begin
                o_tx_start   = 1'b1;
                w_next_state = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (!w_last_byte) begin
                        w_next_state = ST_SEND;
                    end else if (!w_last_addr) begin
                        w_next_state = ST_REQ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        w_next_state = ST_CSUM;
`else
                        w_next_state = ST_DONE;
`endif
                    end
                end
            end
            ST_CSUM: begin
                o_tx_start   = 1'b1;
                w_next_state = ST_CSUM_WAIT;
            end
            ST_CSUM_WAIT: begin
                if (i_tx_done) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
`ifdef DUMP_CHECKSUM_EN
        if (r_state == ST_CSUM || r_state == ST_CSUM_WAIT) o_tx_data = r_csum;
`endif
    end

    // The top byte of r_shift is the byte on the wire; it only moves once the UART acknowledges it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_LATCH: begin
                    r_shift    <= i_read_data;
                    r_byte_cnt <= '0;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (!w_last_byte) begin
                            r_shift    <= r_shift << BYTE_SIZE;
                            r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                        end else if (!w_last_addr) begin
                            r_addr <= r_addr + ADDR_SIZE'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
